// File: rtl/ctx_cost_write_sched.sv
// ctx_cost_write_sched: owns the single write port of a context_bit_regfile.
// A reload sweep rewrites every (ctx, bin) entry from the entropy-bits LUT.
// Outside a sweep, update requesters are served round-robin, at most one per cycle.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   init_start                pulse that starts a reload sweep
//   init_busy, init_done      sweep in progress / one-cycle pulse after the last sweep write
//   req_valid/req_ready       per-requester handshake (req_ready is combinational)
//   req_ctx_addr/bin/cost     packed request payloads; requester r sits at [8r+:8], [r], [16r+:16]
//   lut_idx, lut_data         entropy LUT lookup (lut_data returns in the same cycle)
//   we, ctx_addr, bin_val,
//   bit_cost_in               registered regfile write port
//   err_addr                  sticky flag: an out-of-range request was dropped
module ctx_cost_write_sched #(
  parameter int unsigned NUM_CTX  = 24,
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned CTX_TYPE = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    init_start,
  output logic                    init_busy,
  output logic                    init_done,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*8-1:0]    req_ctx_addr,
  input  logic [NUM_REQ-1:0]      req_bin,
  input  logic [NUM_REQ*16-1:0]   req_cost,
  output logic [6:0]              lut_idx,
  input  logic [15:0]             lut_data,
  output logic                    we,
  output logic [7:0]              ctx_addr,
  output logic                    bin_val,
  output logic [15:0]             bit_cost_in,
  output logic                    err_addr
);

  localparam int unsigned RR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CTX_W    = 7;
  localparam int unsigned STRIDE   = (CTX_TYPE != 0) ? 3 : 2;
  localparam int unsigned LUT_SIZE = 96;

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CTX_W-1:0]  ctx_q, ctx_d;
  logic              bin_q, bin_d;
  logic [RR_W-1:0]   rr_q, rr_d;
  logic              we_d, binv_d, busy_d, done_d, err_d;
  logic [7:0]        addr_d;
  logic [15:0]       cost_d;
  logic [9:0]        lut_lin;

  logic [7:0]        addr_a [NUM_REQ];
  logic              bin_a  [NUM_REQ];
  logic [15:0]       cost_a [NUM_REQ];
  logic [RR_W-1:0]   win, idx;
  logic              found;

  // Unpack the flat request buses into per-requester views.
  always_comb begin
    for (int r = 0; r < NUM_REQ; r++) begin
      addr_a[r] = req_ctx_addr[8*r +: 8];
      bin_a[r]  = req_bin[r];
      cost_a[r] = req_cost[16*r +: 16];
    end
  end

  // Round-robin pick: first valid requester at or after the pointer, wrapping.
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = RR_W'((32'(rr_q) + 32'(k)) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Next-state, grant and write-port next values.
  always_comb begin
    state_d   = state_q;
    ctx_d     = ctx_q;
    bin_d     = bin_q;
    rr_d      = rr_q;
    req_ready = '0;
    lut_idx   = '0;
    we_d      = 1'b0;
    addr_d    = ctx_addr;
    binv_d    = bin_val;
    cost_d    = bit_cost_in;
    err_d     = err_addr;
    lut_lin   = 10'(ctx_q) * 10'(STRIDE) + 10'(bin_q);

    case (state_q)
      S_IDLE: begin
        if (init_start) begin
          // Sweep wins over any pending request this cycle.
          state_d = S_INIT;
          ctx_d   = '0;
          bin_d   = 1'b0;
          err_d   = 1'b0;
        end else if (found) begin
          req_ready[win] = 1'b1;
          rr_d = RR_W'((32'(win) + 32'd1) % NUM_REQ);
          if (32'(addr_a[win]) < NUM_CTX) begin
            we_d   = 1'b1;
            addr_d = addr_a[win];
            binv_d = bin_a[win];
            cost_d = cost_a[win];
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_INIT: begin
        lut_idx = 7'(lut_lin % 10'(LUT_SIZE));
        we_d    = 1'b1;
        addr_d  = 8'(ctx_q);
        binv_d  = bin_q;
        cost_d  = lut_data;
        if (bin_q) begin
          bin_d = 1'b0;
          ctx_d = ctx_q + 1'b1;
          if (ctx_q == CTX_W'(NUM_CTX - 1)) state_d = S_DONE;
        end else begin
          bin_d = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_INIT);
    // DONE is the cycle the last sweep write is visible; the pulse follows it.
    done_d = (state_q == S_DONE);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ctx_q       <= '0;
      bin_q       <= 1'b0;
      rr_q        <= '0;
      we          <= 1'b0;
      ctx_addr    <= '0;
      bin_val     <= 1'b0;
      bit_cost_in <= '0;
      init_busy   <= 1'b0;
      init_done   <= 1'b0;
      err_addr    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ctx_q       <= ctx_d;
      bin_q       <= bin_d;
      rr_q        <= rr_d;
      we          <= we_d;
      ctx_addr    <= addr_d;
      bin_val     <= binv_d;
      bit_cost_in <= cost_d;
      init_busy   <= busy_d;
      init_done   <= done_d;
      err_addr    <= err_d;
    end
  end

endmodule

// File: tb/tb_ctx_cost_write_sched.sv
// Bench for ctx_cost_write_sched: expected regfile writes go into per-instance
// queues; a negedge monitor pops and compares on every write.
module tb_ctx_cost_write_sched;

  localparam int unsigned NC = 24;
  localparam int unsigned NR = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            init_start0, init_start1;
  logic            init_busy0, init_done0, init_busy1, init_done1;
  logic [NR-1:0]   req_valid, req_ready0, req_ready1, req_bin;
  logic [NR*8-1:0] req_ctx_addr;
  logic [NR*16-1:0] req_cost;
  logic [6:0]      lut_idx0, lut_idx1;
  logic [15:0]     lut_data0, lut_data1;
  logic            we0, we1, bin_val0, bin_val1, err0, err1;
  logic [7:0]      ctx_addr0, ctx_addr1;
  logic [15:0]     cost0, cost1;

  typedef struct packed {
    logic [7:0]  a;
    logic        b;
    logic [15:0] c;
  } wr_t;

  wr_t q0[$];
  wr_t q1[$];
  wr_t e0, e1;
  int  total = 0;
  int  bad   = 0;

  // Distinct entry per index so a wrong lut_idx shows up as wrong data.
  function automatic logic [15:0] lut_f(input logic [6:0] i);
    return 16'({9'd0, i} * 16'd257) ^ 16'h5A00;
  endfunction

  assign lut_data0 = lut_f(lut_idx0);
  assign lut_data1 = lut_f(lut_idx1);

  ctx_cost_write_sched #(.NUM_CTX(NC), .NUM_REQ(NR), .CTX_TYPE(0)) dut0 (
    .clk(clk), .rst(rst), .init_start(init_start0),
    .init_busy(init_busy0), .init_done(init_done0),
    .req_valid(req_valid), .req_ready(req_ready0),
    .req_ctx_addr(req_ctx_addr), .req_bin(req_bin), .req_cost(req_cost),
    .lut_idx(lut_idx0), .lut_data(lut_data0),
    .we(we0), .ctx_addr(ctx_addr0), .bin_val(bin_val0),
    .bit_cost_in(cost0), .err_addr(err0)
  );

  ctx_cost_write_sched #(.NUM_CTX(NC), .NUM_REQ(NR), .CTX_TYPE(1)) dut1 (
    .clk(clk), .rst(rst), .init_start(init_start1),
    .init_busy(init_busy1), .init_done(init_done1),
    .req_valid(NR'(0)), .req_ready(req_ready1),
    .req_ctx_addr(16'h0000), .req_bin(NR'(0)), .req_cost(32'h0000_0000),
    .lut_idx(lut_idx1), .lut_data(lut_data1),
    .we(we1), .ctx_addr(ctx_addr1), .bin_val(bin_val1),
    .bit_cost_in(cost1), .err_addr(err1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  function automatic wr_t mk(input logic [7:0] a, input logic b, input logic [15:0] c);
    wr_t w;
    w.a = a;
    w.b = b;
    w.c = c;
    return w;
  endfunction

  // Expected sweep writes: entry i is (ctx=i/2, bin=i%2), LUT index (ctx*s+bin) mod 96.
  task automatic push_sweep(input int q, input int s, input int n);
    for (int i = 0; i < n; i++) begin
      int  c, b, x;
      wr_t w;
      c = i / 2;
      b = i % 2;
      x = (c * s + b) % 96;
      w = mk(8'(c), 1'(b), lut_f(7'(x)));
      if (q == 0) q0.push_back(w);
      else        q1.push_back(w);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (we0) begin
      if (q0.size() == 0) begin
        total++;
        bad++;
        $display("FAIL wr0_unexpected: got addr=%0d bin=%0d cost=%0h expected no write",
                 ctx_addr0, bin_val0, cost0);
      end else begin
        e0 = q0.pop_front();
        chk("wr0", 32'({ctx_addr0, bin_val0, cost0}), 32'(e0));
      end
    end
    if (we1) begin
      if (q1.size() == 0) begin
        total++;
        bad++;
        $display("FAIL wr1_unexpected: got addr=%0d bin=%0d cost=%0h expected no write",
                 ctx_addr1, bin_val1, cost1);
      end else begin
        e1 = q1.pop_front();
        chk("wr1", 32'({ctx_addr1, bin_val1, cost1}), 32'(e1));
      end
    end
  end

  // Full CTX_TYPE=0 sweep with busy/done timing checks.
  task automatic sweep0();
    int first_done, last_we, ndone;
    push_sweep(0, 2, 48);
    @(posedge clk); #1 init_start0 = 1'b1;
    @(posedge clk); #1 init_start0 = 1'b0;
    first_done = -1;
    last_we    = -1;
    ndone      = 0;
    for (int n = 0; n <= 51; n++) begin
      @(negedge clk);
      if (n == 0)  chk("sweep_busy_start", 32'(init_busy0), 32'd1);
      if (n == 47) chk("sweep_busy_mid",   32'(init_busy0), 32'd1);
      if (n == 48) chk("sweep_busy_end",   32'(init_busy0), 32'd0);
      if (we0) last_we = n;
      if (init_done0) begin
        ndone++;
        if (first_done < 0) first_done = n;
      end
    end
    chk("sweep_last_we",    32'(last_we),    32'd48);
    chk("sweep_done_cycle", 32'(first_done), 32'd49);
    chk("sweep_done_count", 32'(ndone),      32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int j0, j1, expg, zeros, got, nd;
    rst          = 1'b1;
    init_start0  = 1'b0;
    init_start1  = 1'b0;
    req_valid    = '0;
    req_bin      = '0;
    req_ctx_addr = '0;
    req_cost     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_we",    32'(we0),        32'd0);
    chk("rst_busy",  32'(init_busy0), 32'd0);
    chk("rst_done",  32'(init_done0), 32'd0);
    chk("rst_err",   32'(err0),       32'd0);
    chk("rst_addr",  32'(ctx_addr0),  32'd0);
    chk("rst_bin",   32'(bin_val0),   32'd0);
    chk("rst_cost",  32'(cost0),      32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // T1: CTX_TYPE=0 sweep.
    sweep0();

    // T3: single request from requester 1.
    @(posedge clk); #1;
    req_valid = 2'b10;
    req_ctx_addr[15:8] = 8'd5;
    req_bin[1] = 1'b1;
    req_cost[31:16] = 16'h1234;
    q0.push_back(mk(8'd5, 1'b1, 16'h1234));
    @(negedge clk);
    chk("t3_ready", 32'(req_ready0), 32'd2);
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    chk("t3_we", 32'(we0), 32'd1);

    // T4: both requesters valid for 6 cycles; pointer is back at 0.
    j0 = 0;
    j1 = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      req_valid = 2'b11;
      req_ctx_addr[7:0]  = 8'(2 + j0);
      req_bin[0]         = j0[0];
      req_cost[15:0]     = 16'h1000 + 16'(j0);
      req_ctx_addr[15:8] = 8'(12 + j1);
      req_bin[1]         = ~j1[0];
      req_cost[31:16]    = 16'h2000 + 16'(j1);
      expg = i % 2;
      @(negedge clk);
      chk("t4_ready", 32'(req_ready0), (expg == 0) ? 32'd1 : 32'd2);
      if (expg == 0) begin
        q0.push_back(mk(8'(2 + j0), j0[0], 16'h1000 + 16'(j0)));
        j0++;
      end else begin
        q0.push_back(mk(8'(12 + j1), ~j1[0], 16'h2000 + 16'(j1)));
        j1++;
      end
    end
    @(posedge clk); #1 req_valid = '0;

    // T5: out-of-range request, then init_start while a request is pending.
    @(posedge clk); #1;
    req_valid = 2'b01;
    req_ctx_addr[7:0] = 8'd30;
    req_bin[0] = 1'b0;
    req_cost[15:0] = 16'hDEAD;
    @(negedge clk);
    chk("t5_ready", 32'(req_ready0), 32'd1);
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    chk("t5_we",  32'(we0),  32'd0);
    chk("t5_err", 32'(err0), 32'd1);
    repeat (3) @(negedge clk);
    chk("t5_err_hold", 32'(err0), 32'd1);
    @(posedge clk); #1;
    req_valid = 2'b01;
    req_ctx_addr[7:0] = 8'd7;
    req_bin[0] = 1'b1;
    req_cost[15:0] = 16'hBEEF;
    init_start0 = 1'b1;
    push_sweep(0, 2, 48);
    q0.push_back(mk(8'd7, 1'b1, 16'hBEEF));
    zeros = 0;
    got   = 0;
    for (int n = 0; n < 100 && got == 0; n++) begin
      @(negedge clk);
      if (n == 1) chk("t5_err_clr", 32'(err0), 32'd0);
      if (req_ready0[0]) got = 1;
      else               zeros++;
      if (n == 0) begin
        @(posedge clk); #1 init_start0 = 1'b0;
      end
    end
    chk("t5_served",      32'(got),   32'd1);
    chk("t5_stall_count", 32'(zeros), 32'd50);
    @(posedge clk); #1 req_valid = '0;

    // T6: reset during the sweep, then a clean restart.
    @(posedge clk); #1 init_start0 = 1'b1;
    push_sweep(0, 2, 9);
    @(posedge clk); #1 init_start0 = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t6_we",   32'(we0),        32'd0);
    chk("t6_busy", 32'(init_busy0), 32'd0);
    nd = 0;
    for (int n = 0; n < 5; n++) begin
      if (init_done0) nd++;
      @(negedge clk);
    end
    chk("t6_no_done", 32'(nd), 32'd0);
    sweep0();

    // T2: CTX_TYPE=1 sweep on the second instance.
    push_sweep(1, 3, 48);
    @(posedge clk); #1 init_start1 = 1'b1;
    @(posedge clk); #1 init_start1 = 1'b0;
    nd = 0;
    repeat (52) begin
      @(negedge clk);
      if (init_done1) nd++;
    end
    chk("t2_done_count", 32'(nd), 32'd1);

    repeat (3) @(negedge clk);
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
